// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe encodings: winner codes and scoreboard state enum.
// No logic; constants only.
// No flow control.
package ttt_pkg;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_X    = 2'b01;
    localparam logic [1:0] W_O    = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_HOLD,
        ST_WAIT_CLR,
        ST_MATCH_OVER
    } ttt_state_t;

endpackage

// File: rtl/ttt_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at MAX.
// Latency: count updates one cycle after inc/clr.
// No backpressure; clr has priority over inc.
module ttt_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ttt_scoreboard.sv
// Match scoreboard downstream of tic_tac_toe: counts results, requests board resets, ends the match.
// Latency: scores/game_over one cycle after result; new_game HOLD_CYCLES after acceptance.
// No backpressure; stale results are ignored until winner returns to none. Option: TTT_SCOREBOARD_DRAW_LIMIT_EN.
module ttt_scoreboard
    import ttt_pkg::*;
#(
    parameter int WINS_TO_MATCH = 3,
    parameter int HOLD_CYCLES   = 2,
    parameter int MAX_DRAWS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] winner,
    input  logic       clear_match,
    output logic [3:0] score_x,
    output logic [3:0] score_o,
    output logic [7:0] draws,
    output logic       game_over,
    output logic       new_game,
    output logic       match_done,
    output logic [1:0] match_winner
);

    localparam logic [3:0] WIN_LAST  = 4'(WINS_TO_MATCH - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

    ttt_state_t state;
    logic [7:0] hold_cnt;
    logic       clr_pend;

    logic accept;
    logic inc_x;
    logic inc_o;
    logic inc_d;
    logic hit_x;
    logic hit_o;
    logic hit_draw;

    // A clear on the same edge discards any result.
    assign accept = (state == ST_PLAY) && (winner != W_NONE) && !clear_match;
    assign inc_x  = accept && (winner == W_X);
    assign inc_o  = accept && (winner == W_O);
    assign inc_d  = accept && (winner == W_DRAW);
    assign hit_x  = inc_x && (score_x == WIN_LAST);
    assign hit_o  = inc_o && (score_o == WIN_LAST);

    ttt_sat_counter #(.WIDTH(4), .MAX(WINS_TO_MATCH)) u_score_x (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_match),
        .inc   (inc_x),
        .count (score_x)
    );

    ttt_sat_counter #(.WIDTH(4), .MAX(WINS_TO_MATCH)) u_score_o (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_match),
        .inc   (inc_o),
        .count (score_o)
    );

    ttt_sat_counter #(.WIDTH(8), .MAX(255)) u_draws (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear_match),
        .inc   (inc_d),
        .count (draws)
    );

`ifdef TTT_SCOREBOARD_DRAW_LIMIT_EN
    logic [3:0] streak;
    logic       streak_clr;

    assign streak_clr = clear_match || inc_x || inc_o;

    ttt_sat_counter #(.WIDTH(4), .MAX(15)) u_streak (
        .clk   (clk),
        .rst   (rst),
        .clr   (streak_clr),
        .inc   (inc_d),
        .count (streak)
    );

    assign hit_draw = inc_d && (streak == 4'(MAX_DRAWS - 1));
`else
    logic unused_max_draws;
    assign unused_max_draws = ^MAX_DRAWS;
    assign hit_draw         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_WAIT_CLR;
            hold_cnt     <= '0;
            clr_pend     <= 1'b0;
            game_over    <= 1'b0;
            new_game     <= 1'b0;
            match_done   <= 1'b0;
            match_winner <= W_NONE;
        end else begin
            game_over <= 1'b0;
            new_game  <= clr_pend;
            clr_pend  <= 1'b0;
            if (clear_match) begin
                state        <= ST_WAIT_CLR;
                hold_cnt     <= '0;
                clr_pend     <= 1'b1;
                match_done   <= 1'b0;
                match_winner <= W_NONE;
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (accept) begin
                            game_over <= 1'b1;
                            hold_cnt  <= HOLD_LOAD;
                            if (hit_x || hit_o || hit_draw) begin
                                state        <= ST_MATCH_OVER;
                                match_done   <= 1'b1;
                                match_winner <= hit_x ? W_X : (hit_o ? W_O : W_DRAW);
                            end else begin
                                state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt <= 8'd1) begin
                            new_game <= 1'b1;
                            state    <= ST_WAIT_CLR;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    ST_WAIT_CLR: begin
                        // Only a cleared board re-arms counting.
                        if (winner == W_NONE) begin
                            state <= ST_PLAY;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
